// File: rtl/render_pkg.sv
// Shared types for the render command queue.
// Renderer register map, command layout and replay FSM states.
package render_pkg;

    localparam logic [3:0] RENDER_ADDR_MODE   = 4'd0;
    localparam logic [3:0] RENDER_ADDR_COORD  = 4'd1;
    localparam logic [3:0] RENDER_ADDR_TEX    = 4'd2;
    localparam logic [3:0] RENDER_ADDR_PARITY = 4'd3;
    localparam logic [3:0] RENDER_ADDR_GO     = 4'd4;

    typedef struct packed {
        logic [6:0] tex;
        logic [8:0] x;
        logic [8:0] y;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    typedef enum logic [2:0] {
        IDLE,
        MODE,
        COORD,
        TEX,
        GO
    } state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous show-ahead FIFO holding queued draw commands.
// Clear wins over push and pop in the same cycle.
module cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int CW    = 25,
    localparam int AW   = $clog2(DEPTH),
    localparam int CNTW = AW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic            clear,
    input  logic [CW-1:0]   wdata,
    output logic [CW-1:0]   rdata,
    output logic            full,
    output logic            empty,
    output logic [CNTW-1:0] count
);

    logic [CW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rptr];
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (do_pop)
                rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/render_cmd_queue.sv
// CPU-facing command queue that replays each draw command to the
// renderer as coords, tex_code and go writes.
module render_cmd_queue
    import render_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = 25,
    localparam int CNTW = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  s_address,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    input  logic        s_read,
    output logic [31:0] s_readdata,
    output logic        s_waitrequest,
    output logic [3:0]  r_address,
    output logic        r_write,
    output logic [31:0] r_writedata,
    input  logic        r_waitrequest
);

    state_t          state;
    state_t          state_n;
    cmd_t            cmd_q;
    cmd_t            cmd_n;
    logic [CW-1:0]   head;
    logic            full;
    logic            empty;
    logic [CNTW-1:0] count;
    logic            push;
    logic            pop;
    logic            ctrl_wr;
    logic            clear;
    logic            can_pop;
    logic            issue;
    logic            mode_q;
    logic            mode_pending;
    logic [31:0]     issued;
    logic            r_write_n;
    logic [3:0]      r_addr_n;
    logic [31:0]     r_data_n;
    logic            unused_wd;

    assign unused_wd     = &{1'b0, s_writedata[31:25]};
    assign push          = s_write & (s_address == 2'd0);
    assign ctrl_wr       = s_write & (s_address == 2'd1);
    assign clear         = ctrl_wr & s_writedata[1];
    assign s_waitrequest = push & full;
    assign can_pop       = ~empty & ~clear;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .wdata (s_writedata[CW-1:0]),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        issue   = 1'b0;
        case (state)
            IDLE: begin
                if (mode_pending) begin
                    state_n = MODE;
                end else if (can_pop) begin
                    pop     = 1'b1;
                    state_n = COORD;
                end
            end
            MODE:  if (!r_waitrequest) state_n = IDLE;
            COORD: if (!r_waitrequest) state_n = TEX;
            TEX:   if (!r_waitrequest) state_n = GO;
            GO: begin
                if (!r_waitrequest) begin
                    issue = 1'b1;
                    if (mode_pending) begin
                        state_n = MODE;
                    end else if (can_pop) begin
                        pop     = 1'b1;
                        state_n = COORD;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        cmd_n = pop ? cmd_t'(head) : cmd_q;
    end

    // Outputs are registered from the next state; MODE data is frozen
    // once presented so a late ctrl write cannot disturb a stalled write.
    always_comb begin
        r_write_n = 1'b0;
        r_addr_n  = '0;
        r_data_n  = '0;
        case (state_n)
            MODE: begin
                r_write_n = 1'b1;
                r_addr_n  = RENDER_ADDR_MODE;
                r_data_n  = (state == MODE) ? r_writedata
                                            : {31'b0, mode_q};
            end
            COORD: begin
                r_write_n = 1'b1;
                r_addr_n  = RENDER_ADDR_COORD;
                r_data_n  = {14'b0, cmd_n.x, cmd_n.y};
            end
            TEX: begin
                r_write_n = 1'b1;
                r_addr_n  = RENDER_ADDR_TEX;
                r_data_n  = {25'b0, cmd_n.tex};
            end
            GO: begin
                r_write_n = 1'b1;
                r_addr_n  = RENDER_ADDR_GO;
            end
            default: ;
        endcase
    end

    // The pending flag drops when MODE is entered; a ctrl write that
    // lands during MODE re-arms it so the newest mode is replayed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q        <= '0;
            mode_q       <= 1'b0;
            mode_pending <= 1'b0;
            issued       <= '0;
            r_write      <= 1'b0;
            r_address    <= '0;
            r_writedata  <= '0;
        end else begin
            cmd_q       <= cmd_n;
            r_write     <= r_write_n;
            r_address   <= r_addr_n;
            r_writedata <= r_data_n;
            if (issue)
                issued <= issued + 1'b1;
            if (ctrl_wr) begin
                mode_q       <= s_writedata[0];
                mode_pending <= 1'b1;
            end else if (state_n == MODE && state != MODE) begin
                mode_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        s_readdata = '0;
        if (s_read) begin
            case (s_address)
                2'd2: s_readdata = {16'b0, 8'(count), 5'b0,
                                    (state != IDLE), full, empty};
                2'd3: s_readdata = issued;
                default: s_readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_render_cmd_queue.sv
// Directed bench for render_cmd_queue: renderer writes are logged
// and compared with hand-computed sequences.
module tb_render_cmd_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  s_address = '0;
    logic        s_write = 1'b0;
    logic [31:0] s_writedata = '0;
    logic        s_read = 1'b0;
    logic [31:0] s_readdata;
    logic        s_waitrequest;
    logic [3:0]  r_address;
    logic        r_write;
    logic [31:0] r_writedata;
    logic        r_waitrequest = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;

    logic [31:0] log_a [$];
    logic [31:0] log_d [$];
    int          log_c [$];

    render_cmd_queue dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_address     (s_address),
        .s_write       (s_write),
        .s_writedata   (s_writedata),
        .s_read        (s_read),
        .s_readdata    (s_readdata),
        .s_waitrequest (s_waitrequest),
        .r_address     (r_address),
        .r_write       (r_write),
        .r_writedata   (r_writedata),
        .r_waitrequest (r_waitrequest)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst_n && r_write && !r_waitrequest) begin
            log_a.push_back({28'b0, r_address});
            log_d.push_back(r_writedata);
            log_c.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cmd(input int tex, input int x,
                                        input int y);
        return {7'b0, 7'(tex), 9'(x), 9'(y)};
    endfunction

    function automatic logic [31:0] coords(input logic [31:0] c);
        return {14'b0, c[17:0]};
    endfunction

    function automatic logic [31:0] texw(input logic [31:0] c);
        return {25'b0, c[24:18]};
    endfunction

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        bit ok = 0;
        @(negedge clk);
        s_address   = a;
        s_writedata = d;
        s_write     = 1'b1;
        for (int i = 0; i < 400; i++) begin
            #1;
            if (!s_waitrequest) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok)
            chk("write_timeout", {31'b0, s_waitrequest}, 32'h0);
        @(posedge clk);
        acc_cyc = cyc;
        #1 s_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        s_address = a;
        s_read    = 1'b1;
        #1 d = s_readdata;
        s_read = 1'b0;
    endtask

    task automatic wait_idle();
        logic [31:0] st = '0;
        int quiet = 0;
        for (int i = 0; i < 2000 && quiet < 3; i++) begin
            cpu_read(2'd2, st);
            if (!st[2] && st[0]) quiet++;
            else quiet = 0;
        end
        if (quiet < 3)
            chk("idle_timeout", st, 32'h1);
    endtask

    task automatic wait_tex(output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (r_write && r_address == 4'd2) begin
                ok = 1;
                break;
            end
        end
        if (!ok)
            chk("tex_timeout", {28'b0, r_address}, 32'h2);
    endtask

    task automatic chk_log(input int k, input logic [31:0] a,
                           input logic [31:0] d);
        chk($sformatf("log%0d_addr", k), log_a[k], a);
        chk($sformatf("log%0d_data", k), log_d[k], d);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] c [18];
        bit ok;
        bit stable;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("rst_r_write", {31'b0, r_write}, 32'h0);
        chk("rst_r_address", {28'b0, r_address}, 32'h0);
        chk("rst_r_writedata", r_writedata, 32'h0);
        chk("rst_s_wait", {31'b0, s_waitrequest}, 32'h0);
        cpu_read(2'd2, rd);
        chk("rst_status", rd, 32'h1);
        cpu_read(2'd3, rd);
        chk("rst_issued", rd, 32'h0);
        cpu_read(2'd0, rd);
        chk("unmapped_rd", rd, 32'h0);

        // single command, no renderer stall
        c[0] = cmd(5, 100, 50);
        cpu_write(2'd0, c[0]);
        repeat (8) @(negedge clk);
        chk("t1_nwr", log_a.size(), 32'd3);
        chk_log(0, 32'd1, 32'h0000C832);
        chk_log(1, 32'd2, 32'd5);
        chk_log(2, 32'd4, 32'd0);
        chk("t1_lat0", log_c[0], acc_cyc + 2);
        chk("t1_lat1", log_c[1], acc_cyc + 3);
        chk("t1_lat2", log_c[2], acc_cyc + 4);
        cpu_read(2'd3, rd);
        chk("t1_issued", rd, 32'd1);
        cpu_read(2'd2, rd);
        chk("t1_status", rd, 32'h1);

        // renderer stalls the TEX write for 10 cycles
        log_a.delete(); log_d.delete(); log_c.delete();
        c[0] = cmd(5, 200, 300);
        cpu_write(2'd0, c[0]);
        wait_tex(ok);
        r_waitrequest = 1'b1;
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(r_write && r_address == 4'd2 && r_writedata == 32'd5))
                stable = 0;
        end
        chk("t2_tex_hold", {31'b0, stable}, 32'h1);
        r_waitrequest = 1'b0;
        wait_idle();
        chk("t2_nwr", log_a.size(), 32'd3);
        chk_log(0, 32'd1, coords(c[0]));
        chk_log(1, 32'd2, 32'd5);
        chk_log(2, 32'd4, 32'd0);
        chk("t2_go_next", log_c[2], log_c[1] + 1);

        // fill while stalled: one command sits in cmd_q, 16 in FIFO,
        // so the 18th push is the one that must stall
        log_a.delete(); log_d.delete(); log_c.delete();
        r_waitrequest = 1'b1;
        for (int i = 0; i < 18; i++)
            c[i] = cmd(i + 1, i * 3, i + 7);
        for (int i = 0; i < 17; i++)
            cpu_write(2'd0, c[i]);
        cpu_read(2'd2, rd);
        chk("t3_status_full", rd, 32'h1006);
        @(negedge clk);
        s_address   = 2'd0;
        s_writedata = c[17];
        s_write     = 1'b1;
        #1 chk("t3_stall0", {31'b0, s_waitrequest}, 32'h1);
        repeat (3) @(negedge clk);
        #1 chk("t3_stall3", {31'b0, s_waitrequest}, 32'h1);
        r_waitrequest = 1'b0;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (!s_waitrequest) begin
                ok = 1;
                break;
            end
        end
        if (!ok)
            chk("t3_accept", {31'b0, s_waitrequest}, 32'h0);
        @(posedge clk);
        #1 s_write = 1'b0;
        wait_idle();
        chk("t3_nwr", log_a.size(), 32'd54);
        for (int i = 0; i < 18; i++) begin
            chk_log(3 * i, 32'd1, coords(c[i]));
            chk_log(3 * i + 1, 32'd2, texw(c[i]));
            chk_log(3 * i + 2, 32'd4, 32'd0);
        end
        cpu_read(2'd3, rd);
        chk("t3_issued", rd, 32'd20);

        // mode change requested while a command is in COORD
        log_a.delete(); log_d.delete(); log_c.delete();
        r_waitrequest = 1'b1;
        c[0] = cmd(10, 11, 12);
        c[1] = cmd(20, 21, 22);
        cpu_write(2'd0, c[0]);
        cpu_write(2'd0, c[1]);
        chk("t4_in_coord", {27'b0, r_write, r_address}, 32'h11);
        cpu_write(2'd1, 32'h1);
        r_waitrequest = 1'b0;
        wait_idle();
        chk("t4_nwr", log_a.size(), 32'd7);
        chk_log(0, 32'd1, coords(c[0]));
        chk_log(1, 32'd2, texw(c[0]));
        chk_log(2, 32'd4, 32'd0);
        chk_log(3, 32'd0, 32'd1);
        chk_log(4, 32'd1, coords(c[1]));
        chk_log(5, 32'd2, texw(c[1]));
        chk_log(6, 32'd4, 32'd0);

        // clear with the head already latched
        log_a.delete(); log_d.delete(); log_c.delete();
        r_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c[i] = cmd(30 + i, 40 + i, 50 + i);
            cpu_write(2'd0, c[i]);
        end
        cpu_read(2'd2, rd);
        chk("t5_pre_clear", rd, 32'h0304);
        cpu_write(2'd1, 32'h2);
        cpu_read(2'd2, rd);
        chk("t5_cleared", rd, 32'h5);
        r_waitrequest = 1'b0;
        wait_idle();
        chk("t5_nwr", log_a.size(), 32'd4);
        chk_log(0, 32'd1, coords(c[0]));
        chk_log(1, 32'd2, texw(c[0]));
        chk_log(2, 32'd4, 32'd0);
        chk_log(3, 32'd0, 32'd0);
        cpu_read(2'd3, rd);
        chk("t5_issued", rd, 32'd23);

        // async reset while TEX is stalled
        log_a.delete(); log_d.delete(); log_c.delete();
        c[0] = cmd(7, 8, 9);
        cpu_write(2'd0, c[0]);
        wait_tex(ok);
        r_waitrequest = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_write", {31'b0, r_write}, 32'h0);
        chk("t6_rst_addr", {28'b0, r_address}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        r_waitrequest = 1'b0;
        repeat (5) @(negedge clk);
        cpu_read(2'd2, rd);
        chk("t6_status", rd, 32'h1);
        cpu_read(2'd3, rd);
        chk("t6_issued", rd, 32'h0);
        chk("t6_nwr", log_a.size(), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
